fila_ctrl: RTL and testbench
============================

// Module: fila_ctrl
//
// PURPOSE
//  Sequencing controller for the deserializer -> fila datapath, clocked by clk_10KHz.
//  Drains the fila one byte at a time into a ready/valid consumer port.
//  Drives the deserializer's ack_in with hysteresis on the fila occupancy (len_out).
//  Flags enqueue attempts into a full fila. Supersedes the combinational length check.
//
// PARAMETERS
//  DATA_W     8  width of fila data and out_data
//  LEN_W      3  width of len_out
//  MAX_LEN    7  len_out value meaning "fila full"
//  HIGH_MARK  6  ack_out drops when len_out >= HIGH_MARK
//  LOW_MARK   3  ack_out returns when len_out <= LOW_MARK (LOW_MARK < HIGH_MARK)
//  DEQ_LAT    1  cycles from the dequeue_out pulse to valid q_data (>= 1)
//  CNT_W      8  width of pop_count
//
// PORTS
//  clk_10KHz    in   1        sole clock, rising edge
//  reset        in   1        asynchronous, active-high
//  len_out      in   LEN_W    fila occupancy
//  enqueue_in   in   1        deserializer data_ready, monitored only
//  q_data       in   DATA_W   fila data_out
//  dequeue_out  out  1        one-cycle pop pulse to fila dequeue_in
//  ack_out      out  1        to deserializer ack_in; 1 = accepting
//  out_data     out  DATA_W   byte presented to the consumer
//  out_valid    out  1        out_data is valid
//  cons_ready   in   1        consumer accepts out_data
//  overflow     out  1        sticky: enqueue seen while fila full
//  clr_err      in   1        clears overflow
//  pop_count    out  CNT_W    bytes delivered, wraps modulo 2^CNT_W
//
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: dequeue_out=0, ack_out=1, out_data=0, out_valid=0, overflow=0, pop_count=0, state=IDLE.
//  - Reset asserted mid-operation: everything returns to reset values immediately.
//    An in-flight byte is discarded; the fila is reset on the same signal.
//  - FSM states: IDLE, POP, WAIT, PRESENT.
//    IDLE:    len_out != 0 -> POP; otherwise stay. No pop is ever issued when len_out == 0.
//    POP:     dequeue_out = 1 for exactly this cycle; load the wait counter with DEQ_LAT-1 -> WAIT.
//    WAIT:    decrement the counter. At 0: out_data <= q_data, out_valid <= 1 -> PRESENT.
//    PRESENT: hold out_data and out_valid stable until cons_ready.
//             On the cons_ready cycle: out_valid <= 0, pop_count <= pop_count+1 (wraps) -> IDLE.
//  - Throughput: at most one byte per DEQ_LAT+3 cycles. Exactly one outstanding pop.
//  - Consumer stall: the FSM holds in PRESENT indefinitely. The fila keeps filling; ack hysteresis throttles the deserializer.
//  - cons_ready while out_valid=0 is ignored.
//  - ack_out, evaluated every cycle independent of the FSM:
//    if ack_out=1 and len_out >= HIGH_MARK -> 0.
//    if ack_out=0 and len_out <= LOW_MARK -> 1.
//    Otherwise hold. Effect is visible one cycle after the threshold is reached.
//  - overflow: set on enqueue_in=1 with len_out==MAX_LEN. Cleared by clr_err.
//    Set and clear in the same cycle: set wins.
//  - Simultaneous enqueue_in and dequeue_out: no special handling; the fila updates len_out itself.
//
// STRUCTURE
//  - fila_pkg: state enum typedef fila_ctrl_state_t, DATA_W/LEN_W defaults.
//  - One sub-module: len_hysteresis (ack_out register + compare logic).
//  - FSM, wait counter, output register, overflow flag and pop counter live in fila_ctrl.
//
// TESTING
//  1 Reset, len_out=0 for 20 cycles -> dequeue_out never 1, ack_out=1, out_valid=0.
//  2 len_out=1, q_data=8'hA5, cons_ready=1 -> one dequeue_out pulse.
//    out_valid=1 with out_data=A5 DEQ_LAT+1 cycles later; pop_count=1 after acceptance.
//  3 cons_ready=0 for 10 cycles with byte presented -> out_data/out_valid stable, no further pulse.
//    cons_ready=1 -> byte accepted, next pop after 1 IDLE cycle.
//  4 len_out ramps 0..7 then back to 0 -> ack_out falls the cycle after len_out=6.
//    ack_out stays 0 at 5 and 4, rises the cycle after len_out=3.
//  5 enqueue_in=1 with len_out=7 -> overflow=1 and sticky.
//    clr_err with simultaneous overflow event -> stays 1; clr_err alone -> 0.
//  6 reset pulse during WAIT -> all outputs at reset values asynchronously, FSM in IDLE.
//    pop_count=8'hFF plus one accepted byte -> 8'h00.

Source files
------------

// File: rtl/fila_pkg.sv
// Shared state type and default widths for the fila sequencing controller.
package fila_pkg;

    localparam int FILA_DATA_W = 8;
    localparam int FILA_LEN_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WAIT,
        PRESENT
    } fila_ctrl_state_t;

endpackage

// File: rtl/len_hysteresis.sv
// Registered accept flag for the deserializer, with hysteresis on fila occupancy.
module len_hysteresis
    import fila_pkg::*;
#(
    parameter int LEN_W     = FILA_LEN_W,
    parameter int HIGH_MARK = 6,
    parameter int LOW_MARK  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] len,
    output logic             ack
);

    // Drop at the high mark, resume only once the fila has drained to the low mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b1;
        end else if (ack && (len >= LEN_W'(HIGH_MARK))) begin
            ack <= 1'b0;
        end else if (!ack && (len <= LEN_W'(LOW_MARK))) begin
            ack <= 1'b1;
        end
    end

endmodule

// File: rtl/fila_ctrl.sv
// Drains the fila one byte at a time into a ready/valid consumer, throttles the
// deserializer through ack_out and flags writes into a full fila.
module fila_ctrl
    import fila_pkg::*;
#(
    parameter int DATA_W    = FILA_DATA_W,
    parameter int LEN_W     = FILA_LEN_W,
    parameter int MAX_LEN   = 7,
    parameter int HIGH_MARK = 6,
    parameter int LOW_MARK  = 3,
    parameter int DEQ_LAT   = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_out,
    input  logic              enqueue_in,
    input  logic [DATA_W-1:0] q_data,
    output logic              dequeue_out,
    output logic              ack_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              cons_ready,
    output logic              overflow,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  pop_count
);

    localparam int WAIT_W = (DEQ_LAT > 1) ? $clog2(DEQ_LAT) : 1;

    fila_ctrl_state_t  state;
    logic [WAIT_W-1:0] wait_cnt;

    len_hysteresis #(
        .LEN_W     (LEN_W),
        .HIGH_MARK (HIGH_MARK),
        .LOW_MARK  (LOW_MARK)
    ) u_hyst (
        .clk (clk_10KHz),
        .rst (reset),
        .len (len_out),
        .ack (ack_out)
    );

    // dequeue_out is raised on entry to POP so the pulse coincides with that state.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            dequeue_out <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            pop_count   <= '0;
        end else begin
            dequeue_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (len_out != '0) begin
                        dequeue_out <= 1'b1;
                        state       <= POP;
                    end
                end
                POP: begin
                    wait_cnt <= WAIT_W'(DEQ_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        out_data  <= q_data;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                PRESENT: begin
                    if (cons_ready) begin
                        out_valid <= 1'b0;
                        pop_count <= pop_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new overflow event outranks a simultaneous clear.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (enqueue_in && (len_out == LEN_W'(MAX_LEN))) begin
            overflow <= 1'b1;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fila_ctrl.sv
// Self-checking bench for fila_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model with a behavioural fila.
module tb_fila_ctrl;

    localparam int DATA_W    = 8;
    localparam int LEN_W     = 3;
    localparam int MAX_LEN   = 7;
    localparam int HIGH_MARK = 6;
    localparam int LOW_MARK  = 3;
    localparam int DEQ_LAT   = 1;
    localparam int CNT_W     = 8;

    logic              clk_10KHz = 1'b0;
    logic              reset;
    logic [LEN_W-1:0]  len_out;
    logic              enqueue_in;
    logic [DATA_W-1:0] q_data;
    logic              dequeue_out;
    logic              ack_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              cons_ready;
    logic              overflow;
    logic              clr_err;
    logic [CNT_W-1:0]  pop_count;

    always #5 clk_10KHz = ~clk_10KHz;

    fila_ctrl #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .MAX_LEN   (MAX_LEN),
        .HIGH_MARK (HIGH_MARK),
        .LOW_MARK  (LOW_MARK),
        .DEQ_LAT   (DEQ_LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_10KHz   (clk_10KHz),
        .reset       (reset),
        .len_out     (len_out),
        .enqueue_in  (enqueue_in),
        .q_data      (q_data),
        .dequeue_out (dequeue_out),
        .ack_out     (ack_out),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .cons_ready  (cons_ready),
        .overflow    (overflow),
        .clr_err     (clr_err),
        .pop_count   (pop_count)
    );

    // Directed phases drive occupancy/data by hand; random phase uses the fila model.
    logic              direct;
    logic [LEN_W-1:0]  direct_len;
    logic [DATA_W-1:0] direct_q;
    logic [LEN_W-1:0]  fila_len;
    logic [DATA_W-1:0] fila_q;
    logic [DATA_W-1:0] fifo[$];
    logic [DATA_W-1:0] sb[$];

    assign len_out = direct ? direct_len : fila_len;
    assign q_data  = direct ? direct_q   : fila_q;

    int n_cmp  = 0;
    int n_fail = 0;
    int stall_left = 0;
    logic rdy;

    int ramp_len [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    int ramp_ack [15] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};

    logic              m_busy;
    int                m_age;
    logic              exp_deq;
    logic              exp_valid;
    logic              exp_ack;
    logic              exp_ovf;
    logic [DATA_W-1:0] exp_data;
    int                exp_cnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] q,
                                 input logic enq, input logic rdy_in, input logic clr);
        direct_len = len;
        direct_q   = q;
        enqueue_in = enq;
        cons_ready = rdy_in;
        clr_err    = clr;
    endtask

    task automatic tick();
        @(posedge clk_10KHz);
        #1;
    endtask

    // Behavioural fila: bytes leave on a pop and appear on q_data DEQ_LAT later.
    always @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            fifo.delete();
            sb.delete();
            fila_len <= '0;
            fila_q   <= '0;
        end else begin
            if (!direct && enqueue_in && (fifo.size() < MAX_LEN))
                fifo.push_back(DATA_W'($urandom));
            if (dequeue_out) begin
                if (direct) begin
                    sb.push_back(direct_q);
                end else if (fifo.size() > 0) begin
                    fila_q <= fifo[0];
                    sb.push_back(fifo[0]);
                    void'(fifo.pop_front());
                end
            end
            fila_len <= LEN_W'(fifo.size());
        end
    end

    // Transaction model: one byte outstanding, visible DEQ_LAT+1 edges after its pop.
    always @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            m_busy    <= 1'b0;
            m_age     <= 0;
            exp_deq   <= 1'b0;
            exp_valid <= 1'b0;
            exp_data  <= '0;
            exp_cnt   <= 0;
            exp_ack   <= 1'b1;
            exp_ovf   <= 1'b0;
        end else begin
            exp_ack <= exp_ack ? (int'(len_out) < HIGH_MARK) : (int'(len_out) <= LOW_MARK);
            if (enqueue_in && (int'(len_out) == MAX_LEN))
                exp_ovf <= 1'b1;
            else if (clr_err)
                exp_ovf <= 1'b0;
            exp_deq <= !m_busy && (len_out != 0);
            if (!m_busy) begin
                if (len_out != 0) begin
                    m_busy <= 1'b1;
                    m_age  <= 0;
                end
            end else if (exp_valid) begin
                if (cons_ready) begin
                    exp_valid <= 1'b0;
                    exp_cnt   <= exp_cnt + 1;
                    m_busy    <= 1'b0;
                end
            end else begin
                if (m_age == DEQ_LAT) begin
                    exp_valid <= 1'b1;
                    exp_data  <= (sb.size() > 0) ? sb.pop_front() : '0;
                end
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk_10KHz) begin
        if (!reset) begin
            checkOutput("dequeue_out", 32'(dequeue_out), 32'(exp_deq));
            checkOutput("ack_out",     32'(ack_out),     32'(exp_ack));
            checkOutput("out_valid",   32'(out_valid),   32'(exp_valid));
            checkOutput("overflow",    32'(overflow),    32'(exp_ovf));
            checkOutput("pop_count",   32'(pop_count),   32'(exp_cnt % (1 << CNT_W)));
            if (exp_valid)
                checkOutput("out_data", 32'(out_data), 32'(exp_data));
        end
    end

    initial begin
        reset  = 1'b1;
        direct = 1'b1;
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;

        $display("[TB] idle with empty fila");
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle_deq",   32'(dequeue_out), 0);
            checkOutput("idle_ack",   32'(ack_out),     1);
            checkOutput("idle_valid", 32'(out_valid),   0);
        end

        $display("[TB] single byte with consumer stall");
        applyStimulus(1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("pop_pulse", 32'(dequeue_out), 1);
        tick();
        checkOutput("pop_once", 32'(dequeue_out), 0);
        checkOutput("wait_valid", 32'(out_valid), 0);
        tick();
        checkOutput("first_valid", 32'(out_valid), 1);
        checkOutput("first_data",  32'(out_data),  32'h A5);
        direct_q = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_valid", 32'(out_valid),   1);
            checkOutput("stall_data",  32'(out_data),    32'h A5);
            checkOutput("stall_deq",   32'(dequeue_out), 0);
        end
        cons_ready = 1'b1;
        tick();
        checkOutput("accept_valid", 32'(out_valid), 0);
        checkOutput("accept_count", 32'(pop_count), 1);
        checkOutput("gap_deq",      32'(dequeue_out), 0);
        tick();
        checkOutput("next_pop", 32'(dequeue_out), 1);
        direct_len = 0;
        repeat (2) tick();
        checkOutput("second_data", 32'(out_data), 32'h 3C);
        tick();
        checkOutput("second_count", 32'(pop_count), 2);

        $display("[TB] occupancy ramp");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(LEN_W'(ramp_len[i]), 8'h5A, 1'b0, 1'b1, 1'b0);
            tick();
            checkOutput("ramp_ack", 32'(ack_out), 32'(ramp_ack[i]));
        end
        repeat (6) tick();

        $display("[TB] overflow flag");
        applyStimulus(7, 8'h5A, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("ovf_set", 32'(overflow), 1);
        applyStimulus(7, 8'h5A, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("ovf_sticky", 32'(overflow), 1);
        applyStimulus(7, 8'h5A, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("ovf_set_wins", 32'(overflow), 1);
        applyStimulus(7, 8'h5A, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("ovf_clear", 32'(overflow), 0);
        applyStimulus(0, 8'h5A, 1'b0, 1'b1, 1'b0);
        repeat (6) tick();

        $display("[TB] reset during wait and counter wrap");
        applyStimulus(1, 8'h77, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("r_pop", 32'(dequeue_out), 1);
        tick();
        checkOutput("r_wait_valid", 32'(out_valid), 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_deq",   32'(dequeue_out), 0);
        checkOutput("rst_ack",   32'(ack_out),     1);
        checkOutput("rst_data",  32'(out_data),    0);
        checkOutput("rst_valid", 32'(out_valid),   0);
        checkOutput("rst_ovf",   32'(overflow),    0);
        checkOutput("rst_count", 32'(pop_count),   0);
        #1 reset = 1'b0;
        tick();
        checkOutput("post_rst_pop",   32'(dequeue_out), 1);
        checkOutput("post_rst_valid", 32'(out_valid),   0);
        cons_ready = 1'b1;
        for (int k = 0; k < 2000 && pop_count != 8'hFF; k++) tick();
        checkOutput("reach_ff", 32'(pop_count), 32'h FF);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        checkOutput("valid_before_wrap", 32'(out_valid), 1);
        tick();
        checkOutput("wrap_count", 32'(pop_count), 0);

        $display("[TB] randomized traffic");
        #1 reset = 1'b1;
        direct = 1'b0;
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (stall_left > 0) begin
                stall_left--;
                rdy = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                stall_left = int'($urandom_range(5, 30));
                rdy = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(0, 8'h00, ($urandom_range(0, 9) < 6), rdy, ($urandom_range(0, 19) == 0));
            tick();
        end
        applyStimulus(0, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
